// File: rtl/serial_comparator_nb_if.sv
// Handshake/operand bundle for serial_comparator_nb.
// Master drives the compare request; slave returns busy/done and the {G,E,L} result.
`default_nettype none

interface serial_comparator_nb_if #(
  parameter int WIDTH = 8
);
  logic             iStart;
  logic             iSigned;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBusy;
  logic             oDone;
  logic [2:0]       oR;

  modport master (
    output iStart, iSigned, iA, iB,
    input  oBusy, oDone, oR
  );

  modport slave (
    input  iStart, iSigned, iA, iB,
    output oBusy, oDone, oR
  );
endinterface

`default_nettype wire

// File: rtl/serial_comparator_nb.sv
// Bit-serial MSB-first magnitude comparator with start/done handshake and
// signed/unsigned mode; result encoded {G,E,L} on oR.
`default_nettype none

module serial_comparator_nb #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic                   iClk,
  input logic                   iRst_n,
  serial_comparator_nb_if.slave bus
);

  localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_TOP = CW'(WIDTH - 1);
  localparam logic [2:0]      R_NONE  = 3'b000;
  localparam logic [2:0]      R_GT    = 3'b100;
  localparam logic [2:0]      R_EQ    = 3'b010;
  localparam logic [2:0]      R_LT    = 3'b001;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic             found_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       held_q;
  logic [2:0]       r_q;
  logic             busy_q;
  logic             done_q;

  logic             a_bit;
  logic             b_bit;
  logic             bit_diff;
  logic             sign_pos;
  logic             a_wins;
  logic [2:0]       bit_res_d;
  logic [2:0]       final_res_d;

  // Operands shift left, so the bit under test is always the register MSB.
  always_comb begin
    a_bit       = a_q[WIDTH-1];
    b_bit       = b_q[WIDTH-1];
    bit_diff    = a_bit ^ b_bit;
    sign_pos    = signed_q && (cnt_q == CNT_TOP);
    // At the sign position a set bit means negative, so the winner flips.
    a_wins      = sign_pos ? b_bit : a_bit;
    bit_res_d   = a_wins ? R_GT : R_LT;
    final_res_d = R_EQ;
    if (found_q) begin
      final_res_d = held_q;
    end else if (bit_diff) begin
      final_res_d = bit_res_d;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      found_q  <= 1'b0;
      cnt_q    <= '0;
      held_q   <= R_NONE;
      r_q      <= R_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iStart) begin
            a_q      <= bus.iA;
            b_q      <= bus.iB;
            signed_q <= bus.iSigned;
            found_q  <= 1'b0;
            held_q   <= R_NONE;
            cnt_q    <= CNT_TOP;
            r_q      <= R_NONE;
            busy_q   <= 1'b1;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (EARLY_EXIT && bit_diff && !found_q) begin
            r_q     <= bit_res_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            r_q     <= final_res_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            found_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            // Full-latency mode keeps the first verdict and ignores later bits.
            if (bit_diff && !found_q) begin
              found_q <= 1'b1;
              held_q  <= bit_res_d;
            end
            cnt_q <= cnt_q - CW'(1);
            a_q   <= {a_q[WIDTH-2:0], 1'b0};
            b_q   <= {b_q[WIDTH-2:0], 1'b0};
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oBusy = busy_q;
  assign bus.oDone = done_q;
  assign bus.oR    = r_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_comparator_nb.sv
// Directed bench for serial_comparator_nb: three instances (W8 early-exit,
// W8 full-latency, W4 early-exit) driven by one linear stimulus sequence.
`default_nettype none

module tb_serial_comparator_nb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_comparator_nb_if #(.WIDTH(8)) if_e8 ();
  serial_comparator_nb_if #(.WIDTH(8)) if_f8 ();
  serial_comparator_nb_if #(.WIDTH(4)) if_e4 ();

  serial_comparator_nb #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e8 (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (if_e8)
  );

  serial_comparator_nb #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f8 (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (if_f8)
  );

  serial_comparator_nb #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut_e4 (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (if_e4)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic sg,
                       input logic [7:0] a, input logic [7:0] b);
    case (sel)
      0: begin if_e8.iStart = st; if_e8.iSigned = sg; if_e8.iA = a; if_e8.iB = b; end
      1: begin if_f8.iStart = st; if_f8.iSigned = sg; if_f8.iA = a; if_f8.iB = b; end
      default: begin
        if_e4.iStart = st; if_e4.iSigned = sg; if_e4.iA = a[3:0]; if_e4.iB = b[3:0];
      end
    endcase
  endtask

  task automatic sample(input int sel, output logic busy, output logic done,
                        output logic [2:0] r);
    case (sel)
      0:       begin busy = if_e8.oBusy; done = if_e8.oDone; r = if_e8.oR; end
      1:       begin busy = if_f8.oBusy; done = if_f8.oDone; r = if_f8.oR; end
      default: begin busy = if_e4.oBusy; done = if_e4.oDone; r = if_e4.oR; end
    endcase
  endtask

  // Called at a falling edge; start is taken at the next rising edge (k) and
  // oDone must appear exactly lat edges later. Returns at the falling edge
  // after the done edge, so a following call starts back-to-back.
  task automatic run(input string tag, input int sel, input logic [7:0] a,
                     input logic [7:0] b, input logic sg, input int lat,
                     input logic [2:0] exp_r, input bit poke);
    logic busy, done;
    logic [2:0] r;
    drive(sel, 1'b1, sg, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, ~sg, ~a, ~b);
    sample(sel, busy, done, r);
    chk({tag, "/acc_busy"}, 8'(busy), 8'd1);
    chk({tag, "/acc_done"}, 8'(done), 8'd0);
    chk({tag, "/acc_r"}, 8'(r), 8'd0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      sample(sel, busy, done, r);
      if (i < lat) begin
        chk({tag, "/mid_busy"}, 8'(busy), 8'd1);
        chk({tag, "/mid_done"}, 8'(done), 8'd0);
        chk({tag, "/mid_r"}, 8'(r), 8'd0);
      end else begin
        chk({tag, "/done"}, 8'(done), 8'd1);
        chk({tag, "/end_busy"}, 8'(busy), 8'd0);
        chk({tag, "/r"}, 8'(r), 8'(exp_r));
      end
      if (poke && i == 1) drive(sel, 1'b1, 1'b0, 8'h00, 8'hFF);
      if (poke && i == 2) drive(sel, 1'b0, 1'b0, 8'h00, 8'hFF);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic busy, done;
    logic [2:0] r;
    bit saw_activity;

    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset state on all instances.
    #12;
    for (int s = 0; s < 3; s++) begin
      sample(s, busy, done, r);
      chk("rst_r", 8'(r), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        sample(s, busy, done, r);
        chk("idle_done", 8'(done), 8'd0);
      end
    end

    // Early exit on W8.
    run("ee_80_7f", 0, 8'h80, 8'h7F, 1'b0, 1, 3'b100, 1'b0);
    @(negedge clk);
    sample(0, busy, done, r);
    chk("hold_r", 8'(r), 8'h04);
    chk("hold_done", 8'(done), 8'd0);
    chk("hold_busy", 8'(busy), 8'd0);
    run("ee_0f_0e", 0, 8'h0F, 8'h0E, 1'b0, 8, 3'b100, 1'b0);
    run("ee_20_30", 0, 8'h20, 8'h30, 1'b0, 4, 3'b001, 1'b0);
    run("eq_a5",    0, 8'hA5, 8'hA5, 1'b0, 8, 3'b010, 1'b0);

    // Signed mode.
    run("s_80_01",  0, 8'h80, 8'h01, 1'b1, 1, 3'b001, 1'b0);
    run("u_80_01",  0, 8'h80, 8'h01, 1'b0, 1, 3'b100, 1'b0);
    run("s_ff_fe",  0, 8'hFF, 8'hFE, 1'b1, 8, 3'b100, 1'b0);
    run("s_7f_80",  0, 8'h7F, 8'h80, 1'b1, 1, 3'b100, 1'b0);

    // Start while busy is ignored; then a back-to-back compare.
    run("busy_start", 0, 8'h0F, 8'h0E, 1'b0, 8, 3'b100, 1'b1);
    run("b2b",        0, 8'h00, 8'hFF, 1'b0, 1, 3'b001, 1'b0);

    // Full-latency instance: later differing bits must not override.
    run("fl_80_7f", 1, 8'h80, 8'h7F, 1'b0, 8, 3'b100, 1'b0);
    run("fl_s8001", 1, 8'h80, 8'h01, 1'b1, 8, 3'b001, 1'b0);
    run("fl_eq",    1, 8'h3C, 8'h3C, 1'b0, 8, 3'b010, 1'b0);

    // W4 regression.
    run("w4_13_12", 2, 8'd13, 8'd12, 1'b0, 4, 3'b100, 1'b0);
    run("w4_5_6",   2, 8'd5,  8'd6,  1'b0, 3, 3'b001, 1'b0);
    run("w4_7_7",   2, 8'd7,  8'd7,  1'b0, 4, 3'b010, 1'b0);

    // Asynchronous reset in the middle of a compare.
    drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 8'h01, 8'h00);
    repeat (3) @(negedge clk);
    sample(0, busy, done, r);
    chk("pre_rst_busy", 8'(busy), 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    sample(0, busy, done, r);
    chk("async_r", 8'(r), 8'd0);
    chk("async_busy", 8'(busy), 8'd0);
    chk("async_done", 8'(done), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_activity = 1'b0;
    repeat (12) begin
      @(negedge clk);
      sample(0, busy, done, r);
      if (done || busy) saw_activity = 1'b1;
    end
    chk("no_resume", 8'(saw_activity), 8'd0);
    run("restart", 0, 8'h01, 8'h00, 1'b0, 8, 3'b100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
